// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, common control characters, byte type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;
  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t CR = 8'h0D;
  localparam byte_t LF = 8'h0A;
endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the echo FIFO: DEPTH x 8, synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  byte_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output byte_t         o_rdata
);

  byte_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Echo-path byte FIFO between UART RX and TX, with optional line-at-a-time release.
// Latency: a committed push at edge N is offered on tx_data/tx_valid right after edge N (show-ahead).
// Backpressure: tx side is valid/ready; rx side has none, so bytes arriving while full are dropped
//   and latched in the sticky overflow flag.
// Ports: clk/rst_n; rx_data/rx_valid input strobe; tx_data/tx_valid/tx_ready output handshake;
//   line_mode release policy; clr_ovf clears overflow; count/empty/full/overflow status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int    DEPTH = 16,
  parameter byte_t TERM  = 8'h0D,
  parameter int    CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  byte_t         rx_data,
  input  logic          rx_valid,
  output byte_t         tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic          line_mode,
  input  logic          clr_ovf,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cm_ptr;
  logic          r_overflow;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_cm_ptr_nxt;
  logic          w_full_nxt;
  byte_t         w_rd_data;

  assign count    = r_wr_ptr - r_rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign tx_valid = (r_rd_ptr != r_cm_ptr);
  assign tx_data  = tx_valid ? w_rd_data : 8'h00;
  assign overflow = r_overflow;

  // A pop frees a slot in the same edge, so a full FIFO can still take a byte.
  assign w_pop  = tx_valid & tx_ready;
  assign w_push = rx_valid & (~full | w_pop);
  assign w_drop = rx_valid & full & ~w_pop;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + CW'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + CW'(w_pop);
    w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_full_nxt   = (w_count_nxt == CW'(DEPTH));
    w_cm_ptr_nxt = r_cm_ptr;
    // Commit everything when not in line mode, on a terminator, or when the
    // buffer fills: an over-long line would otherwise never drain.
    if (!line_mode || (w_push && (rx_data == TERM)) || w_full_nxt) begin
      w_cm_ptr_nxt = w_wr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cm_ptr <= w_cm_ptr_nxt;
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (CW - 1)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[CW-2:0]),
    .i_wdata (rx_data),
    .i_raddr (r_rd_ptr[CW-2:0]),
    .o_rdata (w_rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected bytes into a scoreboard queue,
// a monitor compares tx_data on every accepted transfer; status flags are checked inline.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  byte_t         rx_data;
  logic          rx_valid;
  byte_t         tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          line_mode;
  logic          clr_ovf;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  int n_chk  = 0;
  int n_fail = 0;

  byte_t sb[$];

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .TERM  (8'h0D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .line_mode (line_mode),
    .clr_ovf   (clr_ovf),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid&ready is seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got byte 0x%0h, expected no output (t=%0t)", tx_data, $time);
      end else begin
        byte_t e;
        e = sb.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h (t=%0t)", tx_data, e, $time);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push_byte(input byte_t b, input bit accept);
    rx_data  = b;
    rx_valid = 1'b1;
    if (accept) sb.push_back(b);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    tx_ready = 1'b1;
    for (int k = 0; k < 100 && !empty; k++) step();
    tx_ready = 1'b0;
    chk({name, "_empty"}, 32'(empty), 32'h1);
    chk({name, "_sb_left"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    line_mode = 1'b0;
    clr_ovf   = 1'b0;

    // Reset values, held in reset.
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    #10 rst_n = 1'b1;
    step();

    // Single byte, pass-through mode: show-ahead right after the push edge.
    push_byte(8'h41, 1'b1);
    chk("t1_tx_valid", 32'(tx_valid), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'h41);
    chk("t1_count", 32'(count), 32'h1);
    chk("t1_empty", 32'(empty), 32'h0);
    drain("t1");

    // Fill to DEPTH, then one more is dropped.
    for (int i = 0; i < 17; i++) begin
      push_byte(byte_t'(i), i < 16);
      if (i == 15) begin
        chk("t2_full", 32'(full), 32'h1);
        chk("t2_count16", 32'(count), 32'd16);
        chk("t2_ovf_before", 32'(overflow), 32'h0);
      end
    end
    chk("t2_ovf_set", 32'(overflow), 32'h1);
    chk("t2_count_after_drop", 32'(count), 32'd16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop: byte accepted, no overflow.
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    sb.push_back(8'hAA);
    step();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_full", 32'(full), 32'h1);
    chk("t3_ovf", 32'(overflow), 32'h0);
    chk("t3_head", 32'(tx_data), 32'h01);
    drain("t3");

    // Line mode: held until the terminator, terminator echoed too.
    line_mode = 1'b1;
    push_byte(8'h48, 1'b1);
    push_byte(8'h69, 1'b1);
    chk("t4_held_valid", 32'(tx_valid), 32'h0);
    chk("t4_held_count", 32'(count), 32'd2);
    push_byte(8'h0D, 1'b1);
    chk("t4_commit_valid", 32'(tx_valid), 32'h1);
    chk("t4_commit_data", 32'(tx_data), 32'h48);
    drain("t4");

    // Partial line released by leaving line mode.
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    chk("t5_held_valid", 32'(tx_valid), 32'h0);
    chk("t5_held_count", 32'(count), 32'd3);
    line_mode = 1'b0;
    step();
    chk("t5_release_valid", 32'(tx_valid), 32'h1);
    chk("t5_release_data", 32'(tx_data), 32'h01);
    drain("t5");

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) push_byte(byte_t'(8'h50 + i), 1'b1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("t6_count_before", 32'(count), 32'd3);
    tx_ready = 1'b1;
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'h0);
    chk("t6_rst_count", 32'(count), 32'h0);
    chk("t6_rst_data", 32'(tx_data), 32'h0);
    chk("t6_rst_empty", 32'(empty), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_no_stale", 32'(tx_valid), 32'h0);
    end
    tx_ready = 1'b0;
    push_byte(8'h77, 1'b1);
    chk("t6_post_count", 32'(count), 32'h1);
    chk("t6_post_data", 32'(tx_data), 32'h77);
    drain("t6");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
